// File: rtl/rle_row_decompressor.sv
// Run-length decompressor: turns {value, length} words into ROW_W-bit image rows.
// Optional build macro DECOMP_OVERRUN_CHK_EN enables the sticky overrun flag.
module rle_row_decompressor #(
  parameter int unsigned ROW_W    = 28,
  parameter int unsigned NUM_ROWS = 28,
  parameter int unsigned LEN_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [ROW_W-1:0] row_out,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [15:0]      row_idx,
  output logic             done,
  output logic             overrun
);

  localparam int unsigned FW = $clog2(ROW_W + 1);
  localparam logic [FW-1:0] RowWF = FW'(ROW_W);
  localparam logic [15:0] LastRow = 16'(NUM_ROWS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StFill, StEmit, StDone} state_e;

  state_e           state_q;
  logic [ROW_W-1:0] buf_q;
  logic [FW-1:0]    fill_q;
  logic [LEN_W-1:0] run_left_q;
  logic [15:0]      row_idx_q;
  logic             val_q;
  logic             data_ready_q;
  logic             row_valid_q;
  logic             done_q;

  logic [FW-1:0]    rem;
  logic [FW-1:0]    n;
  logic [ROW_W:0]   ones;
  logic [ROW_W-1:0] mask;
  logic [FW-1:0]    fill_nxt;
  logic [LEN_W-1:0] run_nxt;
  logic             last_row;
  logic             accept;

  // Span of this cycle's write: n pixels starting at pixel index fill (MSB first).
  always_comb begin
    rem = RowWF - fill_q;
    if (run_left_q < LEN_W'(rem)) begin
      n = run_left_q[FW-1:0];
    end else begin
      n = rem;
    end
    ones     = ((ROW_W + 1)'(1) << n) - (ROW_W + 1)'(1);
    mask     = ones[ROW_W-1:0] << (rem - n);
    fill_nxt = fill_q + n;
    run_nxt  = run_left_q - LEN_W'(n);
  end

  assign last_row   = (row_idx_q == LastRow);
  assign data_ready = data_ready_q & ~start;
  assign accept     = data_valid & data_ready;
  assign row_out    = buf_q;
  assign row_valid  = row_valid_q;
  assign row_idx    = row_idx_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      buf_q        <= '0;
      fill_q       <= '0;
      run_left_q   <= '0;
      row_idx_q    <= '0;
      val_q        <= 1'b0;
      data_ready_q <= 1'b0;
      row_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else if (start) begin
      // Begins a new image from any state, abandoning whatever was in flight.
      state_q      <= StLoad;
      buf_q        <= '0;
      fill_q       <= '0;
      run_left_q   <= '0;
      row_idx_q    <= '0;
      data_ready_q <= 1'b1;
      row_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: begin
          if (accept) begin
            val_q      <= data[15];
            run_left_q <= LEN_W'(data[14:0]);
            if (data[14:0] != 15'd0) begin
              state_q      <= StFill;
              data_ready_q <= 1'b0;
            end
          end
        end
        StFill: begin
          buf_q      <= val_q ? (buf_q | mask) : (buf_q & ~mask);
          fill_q     <= fill_nxt;
          run_left_q <= run_nxt;
          if (fill_nxt == RowWF) begin
            state_q     <= StEmit;
            row_valid_q <= 1'b1;
          end else if (run_nxt == '0) begin
            state_q      <= StLoad;
            data_ready_q <= 1'b1;
          end
        end
        StEmit: begin
          if (row_ready) begin
            row_valid_q <= 1'b0;
            fill_q      <= '0;
            buf_q       <= '0;
            if (last_row) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              run_left_q <= '0;
            end else begin
              row_idx_q <= row_idx_q + 16'd1;
              if (run_left_q != '0) begin
                state_q <= StFill;
              end else begin
                state_q      <= StLoad;
                data_ready_q <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DECOMP_OVERRUN_CHK_EN
  logic overrun_q;
  logic img_end_q;
  logic final_hs;

  assign final_hs = (state_q == StEmit) && row_ready && last_row && !start;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      img_end_q <= 1'b0;
    end else begin
      if (start) begin
        img_end_q <= 1'b0;
      end else if (final_hs) begin
        img_end_q <= 1'b1;
      end
      if (final_hs && (run_left_q != '0)) begin
        overrun_q <= 1'b1;
      end
      if (accept && (data[14:0] != 15'd0) && img_end_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rle_row_decompressor.sv
// Scoreboard bench for rle_row_decompressor at ROW_W=8, NUM_ROWS=2.
module tb_rle_row_decompressor;

  localparam int unsigned RW = 8;
  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   data;
  logic          data_valid;
  logic          data_ready;
  logic [RW-1:0] row_out;
  logic          row_valid;
  logic          row_ready;
  logic [15:0]   row_idx;
  logic          done;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [23:0] exp_q[$];

  rle_row_decompressor #(
    .ROW_W   (RW),
    .NUM_ROWS(NR),
    .LEN_W   (15)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .row_out   (row_out),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed row handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        chk("row_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("row_out", 32'(row_out), 32'(e[7:0]));
        chk("row_idx", 32'(row_idx), 32'(e[23:8]));
      end
    end
  end

  task automatic push_row(input logic [15:0] idx, input logic [7:0] row);
    exp_q.push_back({idx, row});
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    data = w;
    data_valid = 1'b1;
    @(negedge clk);
    while (!data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    accept_cyc = cyc;
    sync();
    data_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic found;
    rst = 1'b1;
    start = 1'b0;
    data = '0;
    data_valid = 1'b0;
    row_ready = 1'b1;

    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_row_idx", 32'(row_idx), 32'd0);
    sync();
    rst = 1'b0;

    // 2: full row from one word, latency t+2
    pulse_start();
    push_row(16'd0, 8'hFF);
    send_word(16'h8008);
    n = 0;
    @(negedge clk);
    while (!row_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(cyc - accept_cyc), 32'd2);
    drain("t2_drain");

    // 3: mixed runs with a zero-length no-op word
    sync();
    pulse_start();
    push_row(16'd0, 8'h1F);
    send_word(16'h0003);
    @(negedge clk);
    send_word(16'h0000);
    @(negedge clk);
    chk("zero_len_stays_load", 32'(data_ready), 32'd1);
    chk("zero_len_no_row", 32'(row_valid), 32'd0);
    send_word(16'h8005);
    drain("t3_drain");

    // 4: one word spans both rows, then done
    sync();
    pulse_start();
    push_row(16'd0, 8'hFF);
    push_row(16'd1, 8'hFF);
    send_word(16'h8010);
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      @(negedge clk);
      found = row_valid && row_ready && (row_idx == 16'd1);
      n++;
    end
    chk("t4_second_row", 32'(found), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_idx_held", 32'(row_idx), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("no_ready_after_done", 32'(data_ready), 32'd0);
      @(negedge clk);
    end
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: back-pressure holds the row stable
    sync();
    row_ready = 1'b0;
    pulse_start();
    push_row(16'd0, 8'hFF);
    send_word(16'h8008);
    n = 0;
    @(negedge clk);
    while (!row_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(row_valid), 32'd1);
      chk("hold_row_out", 32'(row_out), 32'hFF);
      chk("hold_row_idx", 32'(row_idx), 32'd0);
      chk("hold_no_ready", 32'(data_ready), 32'd0);
      @(negedge clk);
    end
    sync();
    row_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("accepted_on_rise", 32'(row_valid), 32'd0);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // 6: run longer than the image
    sync();
    pulse_start();
    push_row(16'd0, 8'hFF);
    push_row(16'd1, 8'hFF);
    send_word(16'h8014);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_done_seen", 32'(done), 32'd1);
`ifdef DECOMP_OVERRUN_CHK_EN
    chk("overrun", 32'(overrun), 32'd1);
`else
    chk("overrun", 32'(overrun), 32'd0);
`endif
    drain("t6_drain");

    // 7: abort mid-fill, then an all-zero row
    sync();
    pulse_start();
    send_word(16'h8010);
    pulse_start();
    push_row(16'd0, 8'h00);
    send_word(16'h0008);
    drain("t7_drain");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
